osd_ram_sched: RTL and testbench

Write-port scheduler for the OSD 32×32-bit character RAM. It shares the single RAM write port between two requesters: the host CPU bus, and an internal scanner that copies NUM_SLOTS debug-register words into the RAM once per video frame. Arbitration is round-robin, and at most one write is issued per cycle. The block sits between the CPU/debug register file and the OSD character RAM, in the RAM's write clock domain.

---
 rtl/osd_pkg.sv | 19 +
 rtl/osd_rr_arb2.sv | 36 +++
 rtl/osd_ram_sched.sv | 146 ++++++++++++++
 tb/tb_osd_ram_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD character-RAM write scheduler.
package osd_pkg;

    localparam int CHAR_RAM_WORDS = 32;
    localparam int CHAR_ADDR_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD
    } scan_state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_SCAN
    } gnt_src_e;

endpackage

// File: rtl/osd_rr_arb2.sv
// Two-input round-robin arbiter: req[0]/gnt[0] is the CPU, req[1]/gnt[1] the scanner.
module osd_rr_arb2
    import osd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output gnt_src_e   last_grant
);

    gnt_src_e last_q;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = (last_q == GNT_SCAN) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Starting as "scanner granted last" lets the CPU win the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= GNT_SCAN;
        end else if (gnt[0]) begin
            last_q <= GNT_CPU;
        end else if (gnt[1]) begin
            last_q <= GNT_SCAN;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/osd_ram_sched.sv
// Shares the OSD character-RAM write port between the CPU and the per-frame debug scanner.
// Optional feature macro: OSD_SCHED_FREEZE_EN (freeze halts scanning at a slot boundary).
module osd_ram_sched
    import osd_pkg::*;
#(
    parameter int NUM_SLOTS = 32,
    parameter int BASE_SLOT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   freeze,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [CHAR_ADDR_W-1:0] cpu_addr,
    input  logic [31:0]            cpu_data,
    input  logic [3:0]             cpu_byteena,
    output logic [CHAR_ADDR_W-1:0] reg_rd_addr,
    input  logic [31:0]            reg_rd_data,
    output logic [CHAR_ADDR_W-1:0] char_wr_addr,
    output logic [31:0]            char_in,
    output logic [3:0]             char_byteena,
    output logic                   char_wren,
    output logic                   scan_busy,
    output logic                   scan_done
);

    localparam logic [CHAR_ADDR_W-1:0] LAST_IDX  = CHAR_ADDR_W'(NUM_SLOTS - 1);
    localparam logic [CHAR_ADDR_W-1:0] BASE_ADDR = CHAR_ADDR_W'(BASE_SLOT);

    scan_state_e            state_q, state_d;
    logic [CHAR_ADDR_W-1:0] idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic                   done_d;
    logic [31:0]            hold_q;
    logic                   scan_req;
    logic [1:0]             req;
    logic [1:0]             gnt;
    gnt_src_e               last_grant;
    logic                   run_block;

`ifdef OSD_SCHED_FREEZE_EN
    assign run_block = freeze;
`else
    logic freeze_unused;
    assign freeze_unused = freeze;
    assign run_block     = 1'b0;
`endif

    assign scan_req    = (state_q == HOLD);
    assign scan_busy   = (state_q != IDLE);
    assign reg_rd_addr = idx_q;
    assign req         = {scan_req, cpu_valid & ~reset};
    assign cpu_ready   = ~reset & (~scan_req | (last_grant == GNT_SCAN));

    osd_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        done_d    = 1'b0;

        // A start request during any non-idle cycle (including the final grant) is remembered once.
        if (frame_start && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!run_block && (frame_start || pending_q)) begin
                    state_d   = FETCH;
                    pending_d = 1'b0;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = HOLD;
            HOLD: begin
                if (gnt[1]) begin
                    if (run_block) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + CHAR_ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (run_block) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            scan_done <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            scan_done <= done_d;
            if (state_q == WAIT) begin
                hold_q <= reg_rd_data;
            end
        end
    end

    // Address/data/byteena hold their last values when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_wren    <= 1'b0;
            char_wr_addr <= '0;
            char_in      <= '0;
            char_byteena <= '0;
        end else begin
            char_wren <= |gnt;
            if (gnt[0]) begin
                char_wr_addr <= cpu_addr;
                char_in      <= cpu_data;
                char_byteena <= cpu_byteena;
            end else if (gnt[1]) begin
                char_wr_addr <= BASE_ADDR + idx_q;
                char_in      <= hold_q;
                char_byteena <= '1;
            end
        end
    end

endmodule

// File: tb/tb_osd_ram_sched.sv
// Self-checking bench for osd_ram_sched against a transaction-level scheduling model.
module tb_osd_ram_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, frame_start, freeze, cpu_valid, cpu_ready;
    logic [4:0]  cpu_addr, reg_rd_addr, char_wr_addr;
    logic [31:0] cpu_data, reg_rd_data, char_in;
    logic [3:0]  cpu_byteena, char_byteena;
    logic        char_wren, scan_busy, scan_done;

    logic        fs2, ready2, wren2, busy2, done2;
    logic [4:0]  rd_addr2, wr_addr2;
    logic [31:0] rd_data2, in2;
    logic [3:0]  be2;

    osd_ram_sched dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .freeze(freeze),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_byteena(cpu_byteena), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .char_wr_addr(char_wr_addr), .char_in(char_in),
        .char_byteena(char_byteena), .char_wren(char_wren), .scan_busy(scan_busy),
        .scan_done(scan_done)
    );

    osd_ram_sched #(.NUM_SLOTS(4), .BASE_SLOT(30)) dut2 (
        .clk(clk), .reset(reset), .frame_start(fs2), .freeze(1'b0),
        .cpu_valid(1'b0), .cpu_ready(ready2), .cpu_addr(5'd0),
        .cpu_data(32'd0), .cpu_byteena(4'd0), .reg_rd_addr(rd_addr2),
        .reg_rd_data(rd_data2), .char_wr_addr(wr_addr2), .char_in(in2),
        .char_byteena(be2), .char_wren(wren2), .scan_busy(busy2),
        .scan_done(done2)
    );

    // Debug register file: word k = A5000000 + k, one-cycle read latency.
    always @(posedge clk) begin
        reg_rd_data <= 32'hA5000000 + 32'(reg_rd_addr);
        rd_data2    <= 32'hA5000000 + 32'(rd_addr2);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the scanner wants slot k three cycles after its previous grant
    // (or after the start cycle); the port goes to whichever requester did not win last.
    localparam int NSL  = 32;
    localparam int BASE = 0;
    int   cyc, m_slot, m_ready_at, m_busy_from, m_done_at;
    bit   m_act, m_pend, m_last_scan, m_req_now;
    bit   nxt_wren;
    logic [4:0]  nxt_addr;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_be;
    bit   exp_wren, exp_busy, exp_done, exp_ready;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;

    task automatic model_reset();
        cyc = 0; m_act = 0; m_pend = 0; m_last_scan = 1; m_req_now = 0;
        m_slot = 0; m_ready_at = 0; m_busy_from = 0; m_done_at = -1;
        nxt_wren = 0; nxt_addr = '0; nxt_data = '0; nxt_be = '0;
    endtask

    task automatic model_step();
        exp_wren  = nxt_wren;
        exp_addr  = nxt_addr;
        exp_data  = nxt_data;
        exp_be    = nxt_be;
        exp_busy  = m_act && (cyc >= m_busy_from);
        exp_done  = (cyc == m_done_at);
        m_req_now = m_act && (cyc >= m_ready_at);
        exp_ready = !m_req_now || m_last_scan;
        if (frame_start) begin
            if (exp_busy) m_pend = 1;
            else if (!m_act) begin
                m_act = 1; m_slot = 0; m_busy_from = cyc + 1; m_ready_at = cyc + 3;
            end
        end
        nxt_wren = 0;
        if (cpu_valid && exp_ready) begin
            nxt_wren = 1; nxt_addr = cpu_addr; nxt_data = cpu_data; nxt_be = cpu_byteena;
            m_last_scan = 0;
        end else if (m_req_now) begin
            nxt_wren = 1; nxt_addr = 5'((BASE + m_slot) % 32);
            nxt_data = 32'hA5000000 + 32'(m_slot); nxt_be = 4'hF;
            m_last_scan = 1;
            if (m_slot == NSL - 1) begin
                m_act = 0; m_done_at = cyc + 1;
                if (m_pend) begin
                    m_pend = 0; m_act = 1; m_slot = 0;
                    m_busy_from = cyc + 2; m_ready_at = cyc + 4;
                end
            end else begin
                m_slot++; m_ready_at = cyc + 3;
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; cpu_valid = 1; cpu_addr = 5'd7; cpu_data = 32'h12345678; cpu_byteena = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready got %b want 0", cpu_ready);
            end
            advance();
        end
        reset = 0; cpu_valid = 0;
        model_reset();
        sample();
        checks++;
        if ({cpu_ready, char_wren, char_wr_addr, char_in, char_byteena, reg_rd_addr, scan_busy, scan_done}
            !== {1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got ready=%b wren=%b addr=%h data=%h be=%h rd=%h busy=%b done=%b want 1 0 0 0 0 0 0 0",
                     cpu_ready, char_wren, char_wr_addr, char_in, char_byteena, reg_rd_addr, scan_busy, scan_done);
        end
        advance();
    endtask

    task automatic test_scan();
        int n_wr, t_done;
        n_wr = 0; t_done = -1;
        frame_start = 1;
        for (int c = 0; c < 110; c++) begin
            sample();
            checks++;
            if ({scan_busy, scan_done, char_wren, cpu_ready} !== {exp_busy, exp_done, exp_wren, exp_ready}) begin
                errors++;
                $display("FAIL scan_ctl c=%0d busy,done,wren,ready got %b%b%b%b want %b%b%b%b", c,
                         scan_busy, scan_done, char_wren, cpu_ready, exp_busy, exp_done, exp_wren, exp_ready);
            end
            if (exp_wren) begin
                checks++;
                if ({char_wr_addr, char_in, char_byteena} !== {exp_addr, exp_data, exp_be}) begin
                    errors++;
                    $display("FAIL scan_write c=%0d got %h/%h/%h want %h/%h/%h", c,
                             char_wr_addr, char_in, char_byteena, exp_addr, exp_data, exp_be);
                end
            end
            if (char_wren) n_wr++;
            if (scan_done) t_done = c;
            advance();
            frame_start = 0;
        end
        checks++;
        if (n_wr != 32 || t_done != 97) begin
            errors++; $display("FAIL scan_length got writes=%0d done=%0d want 32 97", n_wr, t_done);
        end
    endtask

    task automatic test_back_to_back();
        int n_wr;
        n_wr = 0;
        for (int c = 0; c < 10; c++) begin
            cpu_valid = (c < 8); cpu_addr = 5'(c); cpu_data = $urandom; cpu_byteena = 4'($urandom);
            sample();
            checks++;
            if ({char_wren, cpu_ready} !== {exp_wren, exp_ready}) begin
                errors++;
                $display("FAIL b2b_ctl c=%0d wren,ready got %b%b want %b%b", c, char_wren, cpu_ready, exp_wren, exp_ready);
            end
            if (exp_wren) begin
                checks++;
                if ({char_wr_addr, char_in, char_byteena} !== {exp_addr, exp_data, exp_be}) begin
                    errors++;
                    $display("FAIL b2b_write c=%0d got %h/%h/%h want %h/%h/%h", c,
                             char_wr_addr, char_in, char_byteena, exp_addr, exp_data, exp_be);
                end
            end
            if (char_wren) n_wr++;
            advance();
        end
        cpu_valid = 0;
        checks++;
        if (n_wr != 8) begin
            errors++; $display("FAIL b2b_count got %0d want 8", n_wr);
        end
    endtask

    task automatic test_cpu_contend();
        int contended, t_done;
        bit hs;
        contended = 0; t_done = -1;
        frame_start = 1;
        cpu_valid = 1; cpu_addr = 5'd3; cpu_data = 32'hDEADBEEF; cpu_byteena = 4'hF;
        for (int c = 0; c < 180; c++) begin
            sample();
            checks++;
            if ({scan_busy, scan_done, char_wren, cpu_ready} !== {exp_busy, exp_done, exp_wren, exp_ready}) begin
                errors++;
                $display("FAIL contend_ctl c=%0d busy,done,wren,ready got %b%b%b%b want %b%b%b%b", c,
                         scan_busy, scan_done, char_wren, cpu_ready, exp_busy, exp_done, exp_wren, exp_ready);
            end
            if (exp_wren) begin
                checks++;
                if ({char_wr_addr, char_in, char_byteena} !== {exp_addr, exp_data, exp_be}) begin
                    errors++;
                    $display("FAIL contend_write c=%0d got %h/%h/%h want %h/%h/%h", c,
                             char_wr_addr, char_in, char_byteena, exp_addr, exp_data, exp_be);
                end
            end
            hs = cpu_valid && exp_ready;
            if (m_req_now && hs) contended++;
            if (scan_done) t_done = c;
            advance();
            frame_start = 0;
            if (c >= 30 && (!cpu_valid || hs)) begin
                cpu_valid   = 1'($urandom_range(0, 1));
                cpu_addr    = 5'($urandom);
                cpu_data    = $urandom;
                cpu_byteena = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            end
        end
        cpu_valid = 0;
        checks++;
        if (t_done != 97 + contended) begin
            errors++; $display("FAIL contend_length got done=%0d want %0d", t_done, 97 + contended);
        end
    endtask

    task automatic test_pending();
        int dones[$];
        for (int c = 0; c < 210; c++) begin
            frame_start = (c == 0 || c == 20 || c == 40);
            sample();
            checks++;
            if ({scan_busy, scan_done, char_wren} !== {exp_busy, exp_done, exp_wren}) begin
                errors++;
                $display("FAIL pend_ctl c=%0d busy,done,wren got %b%b%b want %b%b%b", c,
                         scan_busy, scan_done, char_wren, exp_busy, exp_done, exp_wren);
            end
            if (exp_wren) begin
                checks++;
                if ({char_wr_addr, char_in} !== {exp_addr, exp_data}) begin
                    errors++;
                    $display("FAIL pend_write c=%0d got %h/%h want %h/%h", c, char_wr_addr, char_in, exp_addr, exp_data);
                end
            end
            if (scan_done) dones.push_back(c);
            advance();
        end
        frame_start = 0;
        checks++;
        if (dones.size() != 2 || dones[0] != 97 || dones[1] != 194) begin
            errors++; $display("FAIL pend_done got count=%0d want 2 at 97,194", dones.size());
        end
    endtask

    task automatic test_base_wrap();
        int nw, t_done2;
        nw = 0; t_done2 = -1;
        fs2 = 1;
        for (int c = 0; c < 18; c++) begin
            sample();
            if (wren2) begin
                checks++;
                if (nw > 3 || c != 4 + 3 * nw || wr_addr2 !== 5'((30 + nw) % 32)
                    || in2 !== 32'hA5000000 + 32'(nw) || be2 !== 4'hF) begin
                    errors++;
                    $display("FAIL wrap_write c=%0d n=%0d got %h/%h/%h want %h/%h/f", c, nw,
                             wr_addr2, in2, be2, 5'((30 + nw) % 32), 32'hA5000000 + 32'(nw));
                end
                nw++;
            end
            if (done2) t_done2 = c;
            advance();
            fs2 = 0;
        end
        checks++;
        if (nw != 4 || t_done2 != 13 || busy2 !== 1'b0 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_summary got writes=%0d done=%0d busy=%b ready=%b want 4 13 0 1", nw, t_done2, busy2, ready2);
        end
    endtask

`ifdef OSD_SCHED_FREEZE_EN
    task automatic test_freeze();
        int nw, nd, busy_late;
        nw = 0; nd = 0; busy_late = 0;
        frame_start = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (char_wren) begin
                checks++;
                if (char_wr_addr !== 5'(nw) || char_in !== 32'hA5000000 + 32'(nw) || c != 4 + 3 * nw) begin
                    errors++;
                    $display("FAIL freeze_write c=%0d got %h/%h want %h/%h", c, char_wr_addr, char_in,
                             5'(nw), 32'hA5000000 + 32'(nw));
                end
                nw++;
            end
            if (scan_done) nd++;
            if (c >= 19 && scan_busy) busy_late++;
            advance();
            frame_start = (c == 39);
            freeze = (c >= 15);
        end
        frame_start = 0;
        checks++;
        if (nw != 6 || nd != 0 || busy_late != 0) begin
            errors++;
            $display("FAIL freeze_summary got writes=%0d dones=%0d busy_late=%0d want 6 0 0", nw, nd, busy_late);
        end
        freeze = 0;
        reset = 1; advance(); reset = 0;
        model_reset();
    endtask
`else
    task automatic test_freeze();
        int t_done;
        t_done = -1;
        freeze = 1; frame_start = 1;
        for (int c = 0; c < 105; c++) begin
            sample();
            checks++;
            if ({scan_busy, scan_done, char_wren} !== {exp_busy, exp_done, exp_wren}) begin
                errors++;
                $display("FAIL freeze_ctl c=%0d busy,done,wren got %b%b%b want %b%b%b", c,
                         scan_busy, scan_done, char_wren, exp_busy, exp_done, exp_wren);
            end
            if (scan_done) t_done = c;
            advance();
            frame_start = 0;
        end
        freeze = 0;
        checks++;
        if (t_done != 97) begin
            errors++; $display("FAIL freeze_ignored got done=%0d want 97", t_done);
        end
    endtask
`endif

    task automatic test_reset_hold();
        frame_start = 1;
        for (int c = 0; c < 3; c++) begin
            sample();
            checks++;
            if ({scan_busy, char_wren} !== {exp_busy, exp_wren}) begin
                errors++;
                $display("FAIL rsthold_pre c=%0d busy,wren got %b%b want %b%b", c, scan_busy, char_wren, exp_busy, exp_wren);
            end
            advance();
            frame_start = 0;
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++; $display("FAIL rsthold_ready got %b want 0", cpu_ready);
        end
        advance();
        reset = 0;
        model_reset();
        sample();
        checks++;
        if ({cpu_ready, char_wren, char_wr_addr, char_in, char_byteena, reg_rd_addr, scan_busy, scan_done}
            !== {1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rsthold_values got ready=%b wren=%b addr=%h data=%h be=%h rd=%h busy=%b done=%b",
                     cpu_ready, char_wren, char_wr_addr, char_in, char_byteena, reg_rd_addr, scan_busy, scan_done);
        end
        advance();
        frame_start = 1;
        for (int c = 0; c < 12; c++) begin
            sample();
            checks++;
            if ({scan_busy, char_wren} !== {exp_busy, exp_wren}) begin
                errors++;
                $display("FAIL rsthold_ctl c=%0d busy,wren got %b%b want %b%b", c, scan_busy, char_wren, exp_busy, exp_wren);
            end
            if (c == 4) begin
                checks++;
                if ({char_wren, char_wr_addr, char_in} !== {1'b1, 5'd0, 32'hA5000000}) begin
                    errors++;
                    $display("FAIL rsthold_restart got %b/%h/%h want 1/00/a5000000", char_wren, char_wr_addr, char_in);
                end
            end
            advance();
            frame_start = 0;
        end
    endtask

    initial begin
        reset = 1; frame_start = 0; freeze = 0; cpu_valid = 0;
        cpu_addr = '0; cpu_data = '0; cpu_byteena = '0; fs2 = 0;
        model_reset();
        test_reset();
        test_scan();
        test_back_to_back();
        test_cpu_contend();
        test_pending();
        test_base_wrap();
        test_freeze();
        test_reset_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
